// File: rtl/tpm_regs_arbiter_if.sv
// Requester-side access port of tpm_regs_arbiter: level request held until a one-cycle ack.
// The requester drives req/we/addr/wdata through master; the arbiter returns rdata/ack/err through slave.
interface tpm_regs_arbiter_if;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        ack;
   logic        err;

   modport master (output req, we, addr, wdata, input rdata, ack, err);
   modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/tpm_regs_arbiter.sv
// Shares the TPM FIFO register file's byte port between the host bridge and firmware, with a
// handshake timeout. Optional firmware grant lock is enabled by defining TPM_ARB_FW_LOCK_EN.
module tpm_regs_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   tpm_regs_arbiter_if.slave h_if,
   tpm_regs_arbiter_if.slave f_if,
   input  logic              f_lock_i,
   output logic [15:0]       regs_addr_o,
   inout  wire  [7:0]        regs_data_io,
   output logic              regs_data_wr_o,
   input  logic              regs_wr_done_i,
   output logic              regs_data_req_o,
   input  logic              regs_data_rd_i,
   output logic              busy_o
);

   localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle, StWrAssert, StWrRelease, StRdAssert, StRdRelease, StAck, StRecover
   } state_e;

   state_e      r_state, w_state_d;
   logic        r_gnt_f, w_gnt_f_d;    // 1 = firmware holds the current grant
   logic        r_last_f, w_last_f_d;
   logic [15:0] r_addr, w_addr_d;
   logic [7:0]  r_wdata, w_wdata_d;
   logic [7:0]  r_h_rdata, w_h_rdata_d;
   logic [7:0]  r_f_rdata, w_f_rdata_d;
   logic        r_err, w_err_d;
   logic [7:0]  r_cnt, w_cnt_d;
   logic        r_lock, w_lock_d;
   logic        w_timeout, w_wait, w_h_win, w_drive, w_ack_h, w_ack_f;

`ifndef TPM_ARB_FW_LOCK_EN
   logic unused_f_lock;
   assign unused_f_lock = f_lock_i;
`endif

   assign w_wait  = (r_state == StWrAssert) || (r_state == StWrRelease) ||
                    (r_state == StRdAssert) || (r_state == StRdRelease);
   assign w_h_win = h_if.req && !r_lock && (!f_if.req || r_last_f);

   always_comb begin
      w_state_d   = r_state;
      w_gnt_f_d   = r_gnt_f;
      w_last_f_d  = r_last_f;
      w_addr_d    = r_addr;
      w_wdata_d   = r_wdata;
      w_h_rdata_d = r_h_rdata;
      w_f_rdata_d = r_f_rdata;
      w_err_d     = r_err;
      w_lock_d    = r_lock;
      w_cnt_d     = r_cnt;
      w_timeout   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_h_win) begin
               w_gnt_f_d  = 1'b0;
               w_last_f_d = 1'b0;
               w_addr_d   = h_if.addr;
               w_wdata_d  = h_if.wdata;
               w_err_d    = 1'b0;
               w_state_d  = h_if.we ? StWrAssert : StRdAssert;
            end else if (f_if.req) begin
               w_gnt_f_d  = 1'b1;
               w_last_f_d = 1'b1;
               w_addr_d   = f_if.addr;
               w_wdata_d  = f_if.wdata;
               w_err_d    = 1'b0;
               w_state_d  = f_if.we ? StWrAssert : StRdAssert;
            end
         end
         StWrAssert: begin
            if (regs_wr_done_i) w_state_d = StWrRelease;
            else                w_timeout = (r_cnt == CntLast);
         end
         StWrRelease: begin
            if (!regs_wr_done_i) w_state_d = StAck;
            else                 w_timeout = (r_cnt == CntLast);
         end
         StRdAssert: begin
            if (regs_data_rd_i) begin
               w_state_d = StRdRelease;
               if (r_gnt_f) w_f_rdata_d = regs_data_io;
               else         w_h_rdata_d = regs_data_io;
            end else begin
               w_timeout = (r_cnt == CntLast);
            end
         end
         StRdRelease: begin
            if (!regs_data_rd_i) w_state_d = StAck;
            else                 w_timeout = (r_cnt == CntLast);
         end
         StAck: begin
`ifdef TPM_ARB_FW_LOCK_EN
            if (r_gnt_f) w_lock_d = f_lock_i;
`endif
            // A timed-out register file may still hold a strobe; wait it out before re-granting.
            w_state_d = (r_err && (regs_wr_done_i || regs_data_rd_i)) ? StRecover : StIdle;
         end
         StRecover: begin
            if (!regs_wr_done_i && !regs_data_rd_i) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase

      if (w_timeout) begin
         w_state_d = StAck;
         w_err_d   = 1'b1;
         if (r_gnt_f) w_f_rdata_d = 8'hFF;
         else         w_h_rdata_d = 8'hFF;
      end

      if (w_state_d != r_state) w_cnt_d = 8'd0;
      else if (w_wait)          w_cnt_d = r_cnt + 8'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= StIdle;
         r_gnt_f   <= 1'b0;
         r_last_f  <= 1'b1;
         r_addr    <= 16'h0000;
         r_wdata   <= 8'h00;
         r_h_rdata <= 8'h00;
         r_f_rdata <= 8'h00;
         r_err     <= 1'b0;
         r_cnt     <= 8'd0;
         r_lock    <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_gnt_f   <= w_gnt_f_d;
         r_last_f  <= w_last_f_d;
         r_addr    <= w_addr_d;
         r_wdata   <= w_wdata_d;
         r_h_rdata <= w_h_rdata_d;
         r_f_rdata <= w_f_rdata_d;
         r_err     <= w_err_d;
         r_cnt     <= w_cnt_d;
         r_lock    <= w_lock_d;
      end
   end

   // Strobes and bus drive decode straight from state so reset releases them at once.
   assign w_drive         = (r_state == StWrAssert) || (r_state == StWrRelease);
   assign regs_data_io    = w_drive ? r_wdata : 8'hzz;
   assign regs_data_wr_o  = (r_state == StWrAssert);
   assign regs_data_req_o = (r_state == StRdAssert);
   assign regs_addr_o     = r_addr;
   assign busy_o          = (r_state != StIdle);

   assign w_ack_h    = (r_state == StAck) && !r_gnt_f;
   assign w_ack_f    = (r_state == StAck) && r_gnt_f;
   assign h_if.ack   = w_ack_h;
   assign f_if.ack   = w_ack_f;
   assign h_if.err   = w_ack_h && r_err;
   assign f_if.err   = w_ack_f && r_err;
   assign h_if.rdata = r_h_rdata;
   assign f_if.rdata = r_f_rdata;

endmodule

// File: tb/tb_tpm_regs_arbiter.sv
// Scoreboard bench for tpm_regs_arbiter against a same-clock register-file stub.
// Expected acks are queued by the stimulus and checked by an independent monitor.
module tb_tpm_regs_arbiter;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        f_lock = 1'b0;
   logic [15:0] regs_addr;
   wire  [7:0]  regs_data;
   logic        regs_data_wr, regs_data_req, busy;
   logic        rf_done = 1'b0;
   logic        rf_rd = 1'b0;
   logic        stub_mute = 1'b0;
   logic        stub_force = 1'b0;
   logic [7:0]  mem [256];
   logic [7:0]  rf_out;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;
   int          wr_rise_cyc = -1;
   logic        wr_prev = 1'b0;

   typedef struct {
      bit       is_f;
      bit       chk;
      bit [7:0] rdata;
      bit       err;
      int       cyc;
   } exp_t;
   exp_t sbq[$];

   tpm_regs_arbiter_if h_if ();
   tpm_regs_arbiter_if f_if ();

   tpm_regs_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .h_if           (h_if),
      .f_if           (f_if),
      .f_lock_i       (f_lock),
      .regs_addr_o    (regs_addr),
      .regs_data_io   (regs_data),
      .regs_data_wr_o (regs_data_wr),
      .regs_wr_done_i (rf_done),
      .regs_data_req_o(regs_data_req),
      .regs_data_rd_i (rf_rd),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Register-file stub: each strobe is echoed one cycle later; 0x0F00 is a fixed ID byte.
   assign rf_out    = (regs_addr == 16'h0F00) ? 8'hD1 : mem[regs_addr[7:0]];
   assign regs_data = rf_rd ? rf_out : 8'hzz;
   always @(posedge clk) begin
      rf_done <= stub_mute ? stub_force : regs_data_wr;
      rf_rd   <= regs_data_req;
      if (regs_data_wr) mem[regs_addr[7:0]] <= regs_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input bit is_f, input bit chk, input bit [7:0] rd, input bit err,
                       input int c);
      exp_t e;
      e.is_f = is_f; e.chk = chk; e.rdata = rd; e.err = err; e.cyc = c;
      sbq.push_back(e);
   endtask

   task automatic do_req(input bit is_f, input bit we, input logic [15:0] addr,
                         input logic [7:0] wd, input bit lock, input int gap);
      bit got;
      got = 1'b0;
      repeat (gap) @(negedge clk);
      if (is_f) begin
         f_if.req = 1'b1; f_if.we = we; f_if.addr = addr; f_if.wdata = wd; f_lock = lock;
      end else begin
         h_if.req = 1'b1; h_if.we = we; h_if.addr = addr; h_if.wdata = wd;
      end
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = is_f ? f_if.ack : h_if.ack;
      end
      if (is_f) f_if.req = 1'b0;
      else      h_if.req = 1'b0;
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL ack_wait: port %0d addr %h got no ack, expected one within 100 cycles",
                  is_f, addr);
      end
   endtask

   // Lone access: request raised at c0+1, sampled at c0+2, ack in the 5th cycle (edge c0+6).
   task automatic single(input bit is_f, input bit we, input logic [15:0] addr,
                         input logic [7:0] wd, input bit chk, input logic [7:0] exp_rd);
      int c0;
      @(negedge clk);
      c0 = cyc;
      push(is_f, chk, exp_rd, 1'b0, c0 + 6);
      do_req(is_f, we, addr, wd, 1'b0, 1);
   endtask

   initial begin : monitor
      exp_t        e;
      logic        a_err;
      logic [7:0]  a_rd;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (h_if.ack || f_if.ack) begin
               if (sbq.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_ack: h_ack %0d f_ack %0d at cycle %0d, expected none",
                           h_if.ack, f_if.ack, cyc);
               end else begin
                  e = sbq.pop_front();
                  a_err = e.is_f ? f_if.err : h_if.err;
                  a_rd  = e.is_f ? f_if.rdata : h_if.rdata;
                  n_vec++;
                  if ((h_if.ack && f_if.ack) || (f_if.ack != e.is_f) || (cyc != e.cyc) ||
                      (a_err != e.err) || (e.chk && a_rd != e.rdata)) begin
                     n_err++;
                     $display("FAIL ack: got port %0d cyc %0d err %0d rdata %h, expected port %0d cyc %0d err %0d rdata %h",
                              f_if.ack, cyc, a_err, a_rd, e.is_f, e.cyc, e.err, e.rdata);
                  end
               end
            end
            if (regs_data_wr && regs_data_req) begin
               n_err++;
               $display("FAIL strobe_overlap: data_wr and data_req both 1 at cycle %0d, expected exclusive",
                        cyc);
            end
            if (rf_rd && regs_data !== rf_out) begin
               n_err++;
               $display("FAIL bus_read: bus %h, expected stub byte %h", regs_data, rf_out);
            end
            if (regs_data_wr && !wr_prev) wr_rise_cyc = cyc;
            wr_prev = regs_data_wr;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running at 200us, expected finish");
      $fatal(1);
   end

   initial begin : stim
      int c0;
      h_if.req = 1'b0; h_if.we = 1'b0; h_if.addr = 16'h0; h_if.wdata = 8'h0;
      f_if.req = 1'b0; f_if.we = 1'b0; f_if.addr = 16'h0; f_if.wdata = 8'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_acks", {30'd0, h_if.ack, f_if.ack}, 32'd0);
      check("rst_strobes", {30'd0, regs_data_wr, regs_data_req}, 32'd0);
      check("rst_addr", 32'(regs_addr), 32'd0);
      check("rst_rdata", {16'd0, h_if.rdata, f_if.rdata}, 32'd0);

      // Tie right after reset: host first, firmware one access period (6 cycles) later.
      @(negedge clk);
      c0 = cyc;
      push(1'b0, 1'b0, 8'h00, 1'b0, c0 + 6);
      push(1'b1, 1'b0, 8'h00, 1'b0, c0 + 12);
      fork
         do_req(1'b0, 1'b1, 16'h0020, 8'h11, 1'b0, 1);
         do_req(1'b1, 1'b1, 16'h0021, 8'h22, 1'b0, 1);
      join

      // Lone host write; data_wr must rise in the cycle right after the grant edge.
      @(negedge clk);
      c0 = cyc;
      push(1'b0, 1'b0, 8'h00, 1'b0, c0 + 6);
      do_req(1'b0, 1'b1, 16'h0008, 8'h01, 1'b0, 1);
      check("wr_strobe_cycle", 32'(wr_rise_cyc), 32'(c0 + 2));

      // Host was granted last, so the next tie goes to firmware.
      @(negedge clk);
      c0 = cyc;
      push(1'b1, 1'b0, 8'h00, 1'b0, c0 + 6);
      push(1'b0, 1'b0, 8'h00, 1'b0, c0 + 12);
      fork
         do_req(1'b0, 1'b1, 16'h0023, 8'h44, 1'b0, 1);
         do_req(1'b1, 1'b1, 16'h0022, 8'h33, 1'b0, 1);
      join

      single(1'b0, 1'b0, 16'h0F00, 8'h00, 1'b1, 8'hD1);
      single(1'b0, 1'b0, 16'h0008, 8'h00, 1'b1, 8'h01);
      single(1'b1, 1'b0, 16'h0021, 8'h00, 1'b1, 8'h22);
      single(1'b0, 1'b0, 16'h0023, 8'h00, 1'b1, 8'h44);
      single(1'b1, 1'b1, 16'h0010, 8'hA5, 1'b0, 8'h00);
      single(1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 8'hA5);
      single(1'b0, 1'b0, 16'h0022, 8'h00, 1'b1, 8'h33);

      // Four firmware writes (first three with lock) while the host requests throughout.
      @(negedge clk);
      c0 = cyc;
`ifdef TPM_ARB_FW_LOCK_EN
      push(1'b1, 1'b0, 8'h00, 1'b0, c0 + 6);
      push(1'b1, 1'b0, 8'h00, 1'b0, c0 + 12);
      push(1'b1, 1'b0, 8'h00, 1'b0, c0 + 18);
      push(1'b1, 1'b0, 8'h00, 1'b0, c0 + 24);
      push(1'b0, 1'b0, 8'h00, 1'b0, c0 + 30);
`else
      push(1'b1, 1'b0, 8'h00, 1'b0, c0 + 6);
      push(1'b0, 1'b0, 8'h00, 1'b0, c0 + 12);
      push(1'b1, 1'b0, 8'h00, 1'b0, c0 + 18);
      push(1'b1, 1'b0, 8'h00, 1'b0, c0 + 24);
      push(1'b1, 1'b0, 8'h00, 1'b0, c0 + 30);
`endif
      fork
         for (int i = 0; i < 4; i++)
            do_req(1'b1, 1'b1, 16'h0030 + 16'(i), 8'h60 + 8'(i), (i < 3), 1);
         do_req(1'b0, 1'b1, 16'h0040, 8'h77, 1'b0, 2);
      join
      f_lock = 1'b0;

      // Reset during RD_ASSERT: strobe drops at once, no ack, rdata cleared.
      @(negedge clk);
      h_if.req = 1'b1; h_if.we = 1'b0; h_if.addr = 16'h0F00;
      for (int i = 0; i < 10 && !regs_data_req; i++) @(negedge clk);
      check("pre_rst_req", 32'(regs_data_req), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_req", 32'(regs_data_req), 32'd0);
      check("rst_mid_ack", 32'(h_if.ack), 32'd0);
      h_if.req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_rdata", 32'(h_if.rdata), 32'd0);

      // Stuck write: err ack after 8 waiting cycles; wr_done raised late forces RECOVER.
      stub_mute = 1'b1;
      stub_force = 1'b0;
      @(negedge clk);
      c0 = cyc;
      push(1'b0, 1'b1, 8'hFF, 1'b1, c0 + 10);
      fork
         do_req(1'b0, 1'b1, 16'h0050, 8'h99, 1'b0, 1);
         begin
            repeat (9) @(negedge clk);
            stub_force = 1'b1;
         end
      join
      repeat (3) @(negedge clk);
      check("recover_busy", 32'(busy), 32'd1);
      check("recover_strobe", 32'(regs_data_wr), 32'd0);
      check("timeout_rdata", 32'(h_if.rdata), 32'hFF);
      stub_force = 1'b0;
      repeat (2) @(negedge clk);
      check("recover_exit", 32'(busy), 32'd0);
      stub_mute = 1'b0;

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
